// File: rtl/sigmoid_seq_if.sv
// Sample, result and coefficient-configuration signals of the sigmoid sequencer.
interface sigmoid_seq_if #(
  parameter int unsigned BITS = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_x;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_y;
  logic            cfg_we;
  logic [2:0]      cfg_addr;
  logic [BITS-1:0] cfg_grad;
  logic [BITS-1:0] cfg_off;
  logic            cfg_err;
  logic [15:0]     sat_cnt;

  modport slave (
    input  in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_grad, cfg_off,
    output in_ready, out_valid, out_y, cfg_err, sat_cnt
  );

  modport master (
    output in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_grad, cfg_off,
    input  in_ready, out_valid, out_y, cfg_err, sat_cnt
  );
endinterface

// File: rtl/sigmoid_seq_ctrl.sv
// Sequencer around the Q8.8 piecewise-linear sigmoid: |x| lookup, clamp, saturation
// and negative-side reflection, one sample at a time on valid/ready handshakes.
module sigmoid_seq_ctrl #(
  parameter int unsigned BITS    = 16,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned NSEG    = 6,
  parameter int unsigned SAT_INT = 8
) (
  input logic         clk,
  input logic         rst_n,
  sigmoid_seq_if.slave bus
);

  localparam int unsigned IW = BITS - FRAC;
  localparam int unsigned SW = 3;
  localparam logic [BITS-1:0] ONE     = BITS'(1 << FRAC);
  localparam logic [BITS-1:0] AX_MAX  = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [IW-1:0]   SEG_MAX = IW'(NSEG - 1);
  localparam logic [IW-1:0]   SAT_LIM = IW'(SAT_INT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic signed [BITS-1:0] grad;
    logic signed [BITS-1:0] off;
  } coef_t;

  function automatic coef_t coef_default(input int k);
    coef_t c;
    case (k)
      0:       c = '{grad: BITS'('h003B), off: BITS'('h0080)};
      1:       c = '{grad: BITS'('h0026), off: BITS'('h0090)};
      2:       c = '{grad: BITS'('h0012), off: BITS'('h00BD)};
      3:       c = '{grad: BITS'('h0008), off: BITS'('h00DD)};
      4:       c = '{grad: BITS'('h0003), off: BITS'('h00F0)};
      5:       c = '{grad: BITS'('h0001), off: BITS'('h00F9)};
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [BITS-1:0] out_y_q, out_y_d;
  logic            cfg_err_q, cfg_err_d;
  logic [15:0]     sat_cnt_q, sat_cnt_d;
  logic            sign_q, sign_d;
  logic [BITS-1:0] ax_q, ax_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic            sat_q, sat_d;
  logic            tab_we;
  coef_t           tab [NSEG];

  logic [BITS-1:0] abs_x;
  logic [IW-1:0]   ipart;
  logic [SW-1:0]   seg_in;
  logic            sat_in;
  logic            accept;

  coef_t                    coef_sel;
  logic signed [2*BITS-1:0] grad_w, x_w, prod;
  logic signed [BITS-1:0]   term, alfa;
  logic [BITS-1:0]          p, y_calc;

  // Input magnitude and segment decode; -32768 folds onto the largest positive magnitude.
  always_comb begin
    abs_x = bus.in_x[BITS-1] ? (~bus.in_x + BITS'(1)) : bus.in_x;
    if (abs_x[BITS-1]) abs_x = AX_MAX;
    ipart  = abs_x[BITS-1:FRAC];
    seg_in = (ipart >= SEG_MAX) ? SW'(SEG_MAX) : SW'(ipart);
    sat_in = (ipart >= SAT_LIM);
    accept = bus.in_valid && in_ready_q;
  end

  // Datapath: alfa = off + (grad*x >>> FRAC), clamp to [0, 1.0], then reflect for x < 0.
  always_comb begin
    coef_sel = tab[seg_q];
    grad_w   = {{BITS{coef_sel.grad[BITS-1]}}, coef_sel.grad};
    x_w      = {{BITS{1'b0}}, ax_q};
    prod     = grad_w * x_w;
    term     = BITS'(prod >>> FRAC);
    alfa     = coef_sel.off + term;
    if (sat_q)                      p = ONE;
    else if (alfa[BITS-1])          p = '0;
    else if (alfa > $signed(ONE))   p = ONE;
    else                            p = alfa;
    y_calc = sign_q ? (ONE - p) : p;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    cfg_err_d   = 1'b0;
    sat_cnt_d   = sat_cnt_q;
    sign_d      = sign_q;
    ax_d        = ax_q;
    seg_d       = seg_q;
    sat_d       = sat_q;
    tab_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sign_d     = bus.in_x[BITS-1];
          ax_d       = abs_x;
          seg_d      = seg_in;
          sat_d      = sat_in;
          in_ready_d = 1'b0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        out_y_d     = y_calc;
        out_valid_d = 1'b1;
        if (sat_q) sat_cnt_d = sat_cnt_q + 16'd1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // Table writes only land in an idle cycle that is not also taking a sample.
    if (bus.cfg_we) begin
      if ((state_q == ST_IDLE) && !accept && (32'(bus.cfg_addr) < NSEG)) tab_we = 1'b1;
      else                                                               cfg_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      cfg_err_q   <= 1'b0;
      sat_cnt_q   <= '0;
      sign_q      <= 1'b0;
      ax_q        <= '0;
      seg_q       <= '0;
      sat_q       <= 1'b0;
      for (int k = 0; k < NSEG; k++) tab[SW'(k)] <= coef_default(k);
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      cfg_err_q   <= cfg_err_d;
      sat_cnt_q   <= sat_cnt_d;
      sign_q      <= sign_d;
      ax_q        <= ax_d;
      seg_q       <= seg_d;
      sat_q       <= sat_d;
      if (tab_we) tab[bus.cfg_addr] <= '{grad: bus.cfg_grad, off: bus.cfg_off};
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sigmoid_seq_ctrl.sv
// Directed and randomized bench for sigmoid_seq_ctrl against an arithmetic reference model.
module tb_sigmoid_seq_ctrl;
  logic clk;
  logic rst_n;

  sigmoid_seq_if #(.BITS(16)) bus ();

  sigmoid_seq_ctrl #(.BITS(16), .FRAC(8), .NSEG(6), .SAT_INT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int exp_sat = 0;
  int mgrad[6];
  int moff[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    mgrad = '{'h3B, 'h26, 'h12, 'h08, 'h03, 'h01};
    moff  = '{'h80, 'h90, 'hBD, 'hDD, 'hF0, 'hF9};
    exp_sat = 0;
  endtask

  // Sigmoid from the rules: |x| in whole units picks the segment, saturate at 8, reflect for x<0.
  function automatic logic [15:0] ref_y(input logic [15:0] x, output bit s);
    int xi, ax, ip, sg, v, p;
    xi = int'($signed(x));
    ax = (xi < 0) ? -xi : xi;
    if (ax > 32767) ax = 32767;
    ip = ax / 256;
    s  = (ip >= 8);
    if (s) p = 256;
    else begin
      sg = (ip > 5) ? 5 : ip;
      v  = moff[sg] + ((mgrad[sg] * ax) >>> 8);
      v  = v & 'hFFFF;
      if (v >= 'h8000) v = v - 'h10000;
      p  = (v < 0) ? 0 : ((v > 256) ? 256 : v);
    end
    return 16'((xi < 0) ? (256 - p) : p);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample: accept, result visible on the second edge, optional stall, then handshake.
  task automatic do_sample(input logic [15:0] x, input logic [15:0] exp, input int stall,
                           input string tag);
    bit s;
    logic [15:0] unused_y;
    unused_y = ref_y(x, s);
    @(negedge clk);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_calc_valid"}, bus.out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_y"}, bus.out_y, exp);
    if (s) exp_sat++;
    check({tag, "_sat_cnt"}, bus.sat_cnt, 32'(exp_sat & 'hFFFF));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'h0100;
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_y"}, bus.out_y, exp);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, bus.out_valid, 0);
    check({tag, "_back_ready"}, bus.in_ready, 1);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input int g, input int o, input bit exp_err,
                           input string tag);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_grad = 16'(g);
    bus.cfg_off  = 16'(o);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check({tag, "_err"}, bus.cfg_err, 32'(exp_err));
    if (!exp_err) begin
      mgrad[addr] = g;
      moff[addr]  = o;
    end
    @(negedge clk);
    check({tag, "_err_clear"}, bus.cfg_err, 0);
  endtask

  initial begin
    logic [15:0] sx [6];
    logic [15:0] sy [6];
    logic [15:0] x, y;
    bit s;
    int idx, nout, last, mag;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_grad  = '0;
    bus.cfg_off   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_sat_cnt", bus.sat_cnt, 0);
    rst_n = 1'b1;

    do_sample(16'h0000, 16'h0080, 0, "x0000");
    do_sample(16'h0100, 16'h00B6, 0, "x0100");
    do_sample(16'h0300, 16'h00F5, 0, "x0300");
    do_sample(16'hFF00, 16'h004A, 0, "xFF00");
    do_sample(16'h0A00, 16'h0100, 0, "x0A00");
    do_sample(16'hF600, 16'h0000, 0, "xF600");
    do_sample(16'h8000, 16'h0000, 0, "x8000");
    do_sample(16'h0100, 16'h00B6, 3, "backpressure");

    cfg_write(3'd0, 'h40, 'h80, 1'b0, "cfg_seg0");
    do_sample(16'h0080, 16'h00A0, 0, "cfg_x0080");

    // Write while a result is waiting must be refused.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h0080;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("done_wr_valid", bus.out_valid, 1);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_grad = 16'h7000;
    bus.cfg_off  = 16'h0000;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check("done_wr_err", bus.cfg_err, 1);
    check("done_wr_y", bus.out_y, 16'h00A0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("done_wr_err_clear", bus.cfg_err, 0);
    do_sample(16'h0080, 16'h00A0, 0, "done_wr_unchanged");

    cfg_write(3'd6, 'h1234, 'h1234, 1'b1, "cfg_addr6");
    cfg_write(3'd7, 'h0000, 'h0000, 1'b1, "cfg_addr7");

    // Write coincident with an input handshake: write dropped, sample still taken.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h0080;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_grad = 16'h0000;
    bus.cfg_off  = 16'h0000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    check("coinc_err", bus.cfg_err, 1);
    check("coinc_calc_valid", bus.out_valid, 0);
    @(negedge clk);
    check("coinc_valid", bus.out_valid, 1);
    check("coinc_y", bus.out_y, 16'h00A0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("coinc_drop_valid", bus.out_valid, 0);

    for (int k = 0; k < 6; k++)
      cfg_write(3'(k), int'($urandom_range(0, 127)), int'($urandom_range(0, 'h1FF)) - 'h80,
                1'b0, "cfg_rand");
    for (int n = 0; n < 24; n++) begin
      mag = int'($urandom_range(0, 'h0A00));
      x   = ($urandom_range(0, 1) == 1) ? 16'(-mag) : 16'(mag);
      y   = ref_y(x, s);
      do_sample(x, y, int'($urandom_range(0, 2)), "rand");
    end

    // Reset while computing: result lost, table and counter back to defaults.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h0A00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_sat_cnt", bus.sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_no_result", bus.out_valid, 0);
    do_sample(16'h0000, 16'h0080, 0, "midrst_x0000");
    do_sample(16'h0080, 16'h009D, 0, "midrst_defaults");

    // Reset with a result pending: out_valid must fall without a clock edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h0300;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("asyncrst_pre_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("asyncrst_out_valid", bus.out_valid, 0);
    check("asyncrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Streaming with in_valid and out_ready held high.
    sx = '{16'h0000, 16'h0100, 16'h0300, 16'hFF00, 16'h0A00, 16'hF600};
    for (int k = 0; k < 6; k++) sy[k] = ref_y(sx[k], s);
    idx  = 0;
    nout = 0;
    last = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && nout < 6; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("stream_y", bus.out_y, sy[nout]);
        if (nout > 0) check("stream_spacing", 32'(cyc - last), 3);
        y = ref_y(sx[nout], s);
        if (s) exp_sat++;
        last = cyc;
        nout++;
      end
      if (idx < 6) begin
        bus.in_valid = 1'b1;
        bus.in_x     = sx[idx];
        if (bus.in_ready) idx++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_count", 32'(nout), 6);
    @(negedge clk);
    check("stream_sat_cnt", bus.sat_cnt, 32'(exp_sat & 'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
